// File: rtl/stream_cut_pkg.sv
// Shared types for the stream cut register.
// Occupancy encoding used by the control logic and debug probes.
package stream_cut_pkg;

    typedef enum logic [1:0] {
        CutEmpty = 2'd0,
        CutOne   = 2'd1,
        CutTwo   = 2'd2
    } cut_occ_e;

endpackage

// File: rtl/stream_cut_slot.sv
// One payload register of the cut stage.
// Load enable, synchronous clear (wins over load), async reset.
module stream_cut_slot #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic load_i,
    input  T     d_i,
    output T     q_o
);

    // Payload flop: only moves on load or clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= T'('0);
        end else if (clr_i) begin
            q_o <= T'('0);
        end else if (load_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/stream_cut_register.sv
// Two-entry ready/valid register; every port is driven from a flop.
// Optional SVA checks: define STREAM_CUT_REGISTER_ASSERT_EN.
module stream_cut_register
    import stream_cut_pkg::*;
#(
    parameter type  T      = logic,
    parameter logic Bypass = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    if (Bypass) begin : gen_bypass

        logic unused_bypass;

        assign valid_o       = valid_i;
        assign ready_o       = ready_i;
        assign data_o        = data_i;
        assign unused_bypass = ^{clk_i, rst_ni, clr_i};

`ifdef STREAM_CUT_REGISTER_ASSERT_EN
        // Bypass must stay pure wiring.
        a_bypass_wire: assert property (@(posedge clk_i)
            valid_o == valid_i && ready_o == ready_i && data_o == data_i);
`endif

    end else begin : gen_cut

        cut_occ_e occ_q;
        cut_occ_e occ_d;
        logic     a_full;
        logic     b_full;
        logic     in_hs;
        logic     out_hs;
        logic     a_load;
        logic     b_load;
        logic     a_sel_b;
        T         a_d;
        T         a_q;
        T         b_q;

        assign a_full  = (occ_q != CutEmpty);
        assign b_full  = (occ_q == CutTwo);
        assign ready_o = ~b_full;
        assign valid_o = a_full;
        assign data_o  = a_q;
        assign in_hs   = valid_i & ready_o;
        assign out_hs  = valid_o & ready_i;
        assign a_d     = a_sel_b ? b_q : data_i;

        // Next occupancy and slot load selects from both handshakes.
        always_comb begin
            occ_d   = occ_q;
            a_load  = 1'b0;
            b_load  = 1'b0;
            a_sel_b = 1'b0;
            unique case (occ_q)
                CutEmpty: begin
                    if (in_hs) begin
                        a_load = 1'b1;
                        occ_d  = CutOne;
                    end
                end
                CutOne: begin
                    if (in_hs && out_hs) begin
                        a_load = 1'b1;
                    end else if (in_hs) begin
                        b_load = 1'b1;
                        occ_d  = CutTwo;
                    end else if (out_hs) begin
                        occ_d  = CutEmpty;
                    end
                end
                CutTwo: begin
                    if (out_hs) begin
                        a_load  = 1'b1;
                        a_sel_b = 1'b1;
                        occ_d   = CutOne;
                    end
                end
                default: begin
                    occ_d = CutEmpty;
                end
            endcase
        end

        // Occupancy register; clear empties both slots.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                occ_q <= CutEmpty;
            end else if (clr_i) begin
                occ_q <= CutEmpty;
            end else begin
                occ_q <= occ_d;
            end
        end

        stream_cut_slot #(.T(T)) u_slot_a (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (clr_i),
            .load_i (a_load),
            .d_i    (a_d),
            .q_o    (a_q)
        );

        stream_cut_slot #(.T(T)) u_slot_b (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (clr_i),
            .load_i (b_load),
            .d_i    (data_i),
            .q_o    (b_q)
        );

`ifdef STREAM_CUT_REGISTER_ASSERT_EN
        a_no_b_without_a: assert property (@(posedge clk_i)
            disable iff (!rst_ni) !(b_full && !a_full));
        a_out_stable: assert property (@(posedge clk_i)
            disable iff (!rst_ni)
            (valid_o && !ready_i && !clr_i) |=> (valid_o && $stable(data_o)));
        a_no_in_when_full: assert property (@(posedge clk_i)
            disable iff (!rst_ni) b_full |-> !in_hs);
`endif

    end

endmodule

// File: tb/tb_stream_cut_register.sv
// Directed and scoreboard checks for stream_cut_register.
// Covers reset, streaming, back-pressure, clear, random traffic, bypass.
module tb_stream_cut_register;

    logic       clk_i;
    logic       rst_ni;
    logic       clr_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_i;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] data_o;

    logic       b_clr;
    logic       b_valid_i;
    logic       b_ready_o;
    logic [7:0] b_data_i;
    logic       b_valid_o;
    logic       b_ready_i;
    logic [7:0] b_data_o;

    int tests = 0;
    int fails = 0;

    logic [7:0] q[$];
    int         nxt;
    logic       exp_v;
    logic       exp_r;

    stream_cut_register #(.T(logic [7:0]), .Bypass(1'b0)) u_dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    stream_cut_register #(.T(logic [7:0]), .Bypass(1'b1)) u_byp (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (b_clr),
        .valid_i (b_valid_i),
        .ready_o (b_ready_o),
        .data_i  (b_data_i),
        .valid_o (b_valid_o),
        .ready_i (b_ready_i),
        .data_o  (b_data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni    = 1'b0;
        clr_i     = 1'b0;
        valid_i   = 1'b1;
        data_i    = 8'h55;
        ready_i   = 1'b0;
        b_clr     = 1'b0;
        b_valid_i = 1'b0;
        b_ready_i = 1'b0;
        b_data_i  = 8'h00;

        // Reset held with valid_i high
        tick();
        tick();
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_data", data_o, 8'h00);
        rst_ni = 1'b1;
        tick();
        check("first_valid", valid_o, 1);
        check("first_data", data_o, 8'h55);
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        check("first_drain", valid_o, 0);

        // Back-to-back streaming, one-cycle lag
        for (int i = 1; i <= 16; i++) begin
            valid_i = 1'b1;
            data_i  = 8'(i);
            tick();
            check("str_valid", valid_o, 1);
            check("str_data", data_o, 32'(i));
            check("str_ready", ready_o, 1);
        end
        valid_i = 1'b0;
        tick();
        check("str_idle", valid_o, 0);

        // Back-pressure fills the spill slot
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h0A;
        tick();
        check("bp1_ready", ready_o, 1);
        check("bp1_data", data_o, 8'h0A);
        data_i = 8'h0B;
        tick();
        check("bp2_ready", ready_o, 0);
        check("bp2_valid", valid_o, 1);
        check("bp2_data", data_o, 8'h0A);
        data_i = 8'h0C;
        tick();
        check("bp3_ready", ready_o, 0);
        check("bp3_data", data_o, 8'h0A);
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        check("bp4_data", data_o, 8'h0B);
        check("bp4_ready", ready_o, 1);
        tick();
        check("bp5_valid", valid_o, 0);

        // Clear from TWO with valid_i asserted
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h05;
        tick();
        data_i = 8'h06;
        tick();
        check("clr_pre_ready", ready_o, 0);
        clr_i  = 1'b1;
        data_i = 8'h07;
        tick();
        clr_i   = 1'b0;
        valid_i = 1'b0;
        check("clr_valid", valid_o, 0);
        check("clr_ready", ready_o, 1);
        ready_i = 1'b1;
        tick();
        check("clr_after", valid_o, 0);

        // Clear drops a beat handshaked in the same cycle
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h08;
        tick();
        clr_i  = 1'b1;
        data_i = 8'h09;
        tick();
        clr_i   = 1'b0;
        valid_i = 1'b0;
        check("clr1_valid", valid_o, 0);
        check("clr1_ready", ready_o, 1);

        // Async reset mid-transfer
        valid_i = 1'b1;
        data_i  = 8'h11;
        tick();
        tick();
        check("amid_full", ready_o, 0);
        valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", valid_o, 0);
        check("arst_ready", ready_o, 1);
        check("arst_data", data_o, 8'h00);
        tick();
        rst_ni = 1'b1;
        tick();

        // Random traffic against a queue model
        nxt = 8'h20;
        for (int c = 0; c < 4000; c++) begin
            valid_i = 1'($urandom_range(0, 1));
            ready_i = 1'($urandom_range(0, 3) != 0);
            data_i  = 8'(nxt);
            exp_v   = (q.size() > 0);
            exp_r   = (q.size() < 2);
            check("rnd_valid", valid_o, exp_v);
            check("rnd_ready", ready_o, exp_r);
            if (exp_v) check("rnd_data", data_o, q[0]);
            tick();
            if (exp_v && ready_i) void'(q.pop_front());
            if (valid_i && exp_r) begin
                q.push_back(data_i);
                nxt++;
            end
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        tick();
        check("rnd_drain", valid_o, 0);

        // Bypass: pure wires, clear ignored
        for (int k = 0; k < 8; k++) begin
            b_valid_i = k[0];
            b_ready_i = k[1];
            b_clr     = k[2];
            b_data_i  = 8'(8'h30 + k);
            #1;
            check("byp_valid", b_valid_o, 32'(k[0]));
            check("byp_ready", b_ready_o, 32'(k[1]));
            check("byp_data", b_data_o, 32'(8'h30 + k));
            tick();
            check("byp_hold", b_data_o, 32'(8'h30 + k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
